// File: rtl/instr_store_pkg.sv
// Shared types and default geometry for the loadable instruction store and its consumers.
package instr_store_pkg;

  localparam int IS_IW    = 8;
  localparam int IS_DEPTH = 32;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_LOADING = 2'd1,
    ST_READY   = 2'd2
  } state_e;

endpackage

// File: rtl/instr_mem_array.sv
// DEPTH x IW storage with one write port and a registered, read-enabled read port.
module instr_mem_array #(
  parameter int IW    = 8,
  parameter int DEPTH = 32,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [IW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [IW-1:0] rdata_o
);

  logic [IW-1:0] mem_q [DEPTH];
  logic [IW-1:0] rdata_q;

  // Contents are deliberately not reset; the read register holds between enabled reads.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/instr_store.sv
// Loadable instruction store: streamed program load, 1-cycle fetch with error responses.
module instr_store
  import instr_store_pkg::*;
#(
  parameter  int IW    = IS_IW,
  parameter  int DEPTH = IS_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          clear,
  input  logic          load_start,
  input  logic          load_valid,
  input  logic [IW-1:0] load_data,
  input  logic          load_last,
  output logic          load_ready,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  output logic          fetch_valid,
  output logic [IW-1:0] fetch_data,
  output logic          fetch_err,
  output logic [AW:0]   prog_len,
  output logic          truncated,
  output logic          busy
);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_W  = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] ONE_W   = (AW+1)'(1);

  state_e        state_q;
  logic [AW:0]   wr_ptr_q;
  logic [AW:0]   prog_len_q;
  logic          trunc_q;

  logic          fvalid_q;
  logic          ferr_q;
  logic          fzero_q;

  logic          accept;
  logic          fetch_ok;
  logic          rd_en;
  logic [AW:0]   wr_ptr_d;
  logic [IW-1:0] rd_data;

  assign load_ready = (state_q == ST_LOADING) && (wr_ptr_q < DEPTH_W) && !load_start;
  assign accept     = load_valid && load_ready;
  assign wr_ptr_d   = wr_ptr_q + ONE_W;
  assign fetch_ok   = (state_q == ST_READY) && ({1'b0, fetch_addr} < prog_len_q);
  assign rd_en      = fetch_req && fetch_ok;

  // A restart always wins over a beat presented in the same cycle.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q    <= ST_EMPTY;
      wr_ptr_q   <= '0;
      prog_len_q <= '0;
      trunc_q    <= 1'b0;
    end else if (load_start) begin
      state_q    <= ST_LOADING;
      wr_ptr_q   <= '0;
      prog_len_q <= '0;
      trunc_q    <= 1'b0;
    end else if (accept) begin
      wr_ptr_q <= wr_ptr_d;
      if (load_last) begin
        state_q    <= ST_READY;
        prog_len_q <= wr_ptr_d;
      end else if (wr_ptr_q == LAST_W) begin
        state_q    <= ST_READY;
        prog_len_q <= DEPTH_W;
        trunc_q    <= 1'b1;
      end
    end
  end

  // fzero_q forces the data output to 0 after an error and holds across idle cycles.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      fvalid_q <= 1'b0;
      ferr_q   <= 1'b0;
      fzero_q  <= 1'b1;
    end else begin
      fvalid_q <= fetch_req;
      ferr_q   <= fetch_req && !fetch_ok;
      if (fetch_req) begin
        fzero_q <= !fetch_ok;
      end
    end
  end

  instr_mem_array #(
    .IW    (IW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (accept),
    .waddr_i (wr_ptr_q[AW-1:0]),
    .wdata_i (load_data),
    .re_i    (rd_en),
    .raddr_i (fetch_addr),
    .rdata_o (rd_data)
  );

  assign fetch_valid = fvalid_q;
  assign fetch_err   = ferr_q;
  assign fetch_data  = fzero_q ? '0 : rd_data;
  assign prog_len    = prog_len_q;
  assign truncated   = trunc_q;
  assign busy        = (state_q == ST_LOADING);

endmodule

// File: tb/tb_instr_store.sv
// Self-checking bench for instr_store: queue-based program model plus literal spot checks.
module tb_instr_store;

  localparam int IW    = 8;
  localparam int DEPTH = 32;
  localparam int AW    = 5;

  logic          clk;
  logic          clear;
  logic          load_start;
  logic          load_valid;
  logic [IW-1:0] load_data;
  logic          load_last;
  logic          load_ready;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_valid;
  logic [IW-1:0] fetch_data;
  logic          fetch_err;
  logic [AW:0]   prog_len;
  logic          truncated;
  logic          busy;

  instr_store #(.IW(IW), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .clear       (clear),
    .load_start  (load_start),
    .load_valid  (load_valid),
    .load_data   (load_data),
    .load_last   (load_last),
    .load_ready  (load_ready),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .fetch_err   (fetch_err),
    .prog_len    (prog_len),
    .truncated   (truncated),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the program being streamed in, and the committed program that fetches see.
  bit            m_loading;
  bit            m_ready;
  logic [IW-1:0] loadq[$];
  logic [IW-1:0] prog[$];
  bit            exp_fv;
  bit            exp_fe;
  bit            exp_trunc;
  logic [IW-1:0] exp_fd;

  int errors = 0;
  int checks = 0;
  bit done   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_loading = 0;
    m_ready   = 0;
    loadq.delete();
    prog.delete();
    exp_fv    = 0;
    exp_fe    = 0;
    exp_fd    = '0;
    exp_trunc = 0;
  endtask

  task automatic model_edge();
    if (fetch_req) begin
      exp_fv = 1;
      if (m_ready && int'(fetch_addr) < prog.size()) begin
        exp_fe = 0;
        exp_fd = prog[fetch_addr];
      end else begin
        exp_fe = 1;
        exp_fd = '0;
      end
    end else begin
      exp_fv = 0;
      exp_fe = 0;
    end
    if (load_start) begin
      m_loading = 1;
      m_ready   = 0;
      loadq.delete();
      prog.delete();
      exp_trunc = 0;
    end else if (m_loading && load_valid && loadq.size() < DEPTH) begin
      loadq.push_back(load_data);
      if (load_last || loadq.size() == DEPTH) begin
        exp_trunc = !load_last;
        prog      = loadq;
        m_loading = 0;
        m_ready   = 1;
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!done && !clear) begin
      check("fetch_valid", 32'(fetch_valid), 32'(exp_fv));
      check("fetch_err",   32'(fetch_err),   32'(exp_fe));
      check("fetch_data",  32'(fetch_data),  32'(exp_fd));
      check("prog_len",    32'(prog_len),    32'(prog.size()));
      check("truncated",   32'(truncated),   32'(exp_trunc));
      check("busy",        32'(busy),        32'(m_loading));
      check("load_ready",  32'(load_ready),
            32'(m_loading && loadq.size() < DEPTH && !load_start));
    end
  end

  task automatic step();
    @(posedge clk);
    model_edge();
    #2;
  endtask

  task automatic idle_inputs();
    load_start = 0;
    load_valid = 0;
    load_data  = '0;
    load_last  = 0;
    fetch_req  = 0;
    fetch_addr = '0;
  endtask

  task automatic fetch(input int addr);
    idle_inputs();
    fetch_req  = 1;
    fetch_addr = AW'(addr);
    step();
    fetch_req  = 0;
  endtask

  task automatic start_load();
    idle_inputs();
    load_start = 1;
    step();
    load_start = 0;
  endtask

  task automatic beat(input logic [IW-1:0] d, input bit last);
    idle_inputs();
    load_valid = 1;
    load_data  = d;
    load_last  = last;
    step();
    load_valid = 0;
    load_last  = 0;
  endtask

  task automatic async_clear();
    idle_inputs();
    clear = 1;
    model_reset();
    #1;
    check("clr_busy",       32'(busy),        32'(0));
    check("clr_prog_len",   32'(prog_len),    32'(0));
    check("clr_load_ready", 32'(load_ready),  32'(0));
    check("clr_fetch_valid",32'(fetch_valid), 32'(0));
    check("clr_fetch_data", 32'(fetch_data),  32'(0));
    #1;
    clear = 0;
  endtask

  logic [IW-1:0] prog5 [5] = '{8'h44, 8'h49, 8'h18, 8'h89, 8'hC3};
  logic [IW-1:0] full_w [DEPTH];

  initial begin
    idle_inputs();
    clear = 1;
    model_reset();
    #3;
    check("rst_fetch_valid", 32'(fetch_valid), 32'(0));
    check("rst_fetch_err",   32'(fetch_err),   32'(0));
    check("rst_fetch_data",  32'(fetch_data),  32'(0));
    check("rst_prog_len",    32'(prog_len),    32'(0));
    check("rst_truncated",   32'(truncated),   32'(0));
    check("rst_busy",        32'(busy),        32'(0));
    #5;
    clear = 0;

    fetch(0);
    check("empty_fetch_valid", 32'(fetch_valid), 32'(1));
    check("empty_fetch_err",   32'(fetch_err),   32'(1));
    check("empty_fetch_data",  32'(fetch_data),  32'(0));

    start_load();
    check("busy_loading", 32'(busy), 32'(1));
    for (int i = 0; i < 5; i++) beat(prog5[i], i == 4);
    check("p5_prog_len",  32'(prog_len),  32'(5));
    check("p5_truncated", 32'(truncated), 32'(0));
    check("p5_busy",      32'(busy),      32'(0));
    fetch(3);
    check("p5_addr3_data", 32'(fetch_data), 32'(8'h89));
    check("p5_addr3_err",  32'(fetch_err),  32'(0));
    fetch(5);
    check("p5_addr5_err",  32'(fetch_err),  32'(1));
    check("p5_addr5_data", 32'(fetch_data), 32'(0));

    start_load();
    for (int i = 0; i < DEPTH; i++) begin
      full_w[i] = IW'($urandom_range(0, 255));
      beat(full_w[i], 1'b0);
    end
    check("full_prog_len",  32'(prog_len),  32'(32));
    check("full_truncated", 32'(truncated), 32'(1));
    load_valid = 1;
    load_data  = 8'hAA;
    #1;
    check("full_load_ready", 32'(load_ready), 32'(0));
    step();
    load_valid = 0;
    check("full_33rd_len", 32'(prog_len), 32'(32));
    fetch(31);
    check("full_addr31", 32'(fetch_data), 32'(full_w[31]));

    idle_inputs();
    load_start = 1;
    fetch_req  = 1;
    fetch_addr = 5'd30;
    step();
    check("start_fetch_old", 32'(fetch_data), 32'(full_w[30]));
    check("start_fetch_err", 32'(fetch_err),  32'(0));
    idle_inputs();
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    idle_inputs();
    load_start = 1;
    load_valid = 1;
    load_data  = 8'h33;
    step();
    beat(8'h55, 1'b1);
    check("restart_len", 32'(prog_len), 32'(1));
    fetch(0);
    check("restart_addr0", 32'(fetch_data), 32'(8'h55));

    start_load();
    for (int i = 0; i < 3; i++) beat(IW'(8'hA0 + i), i == 2);
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      fetch_req  = 1;
      fetch_addr = AW'(i);
      step();
      check("b2b_valid", 32'(fetch_valid), 32'(1));
      check("b2b_data",  32'(fetch_data),  32'(8'hA0 + i));
    end
    idle_inputs();
    step();
    check("hold_data",  32'(fetch_data),  32'(8'hA2));
    check("hold_valid", 32'(fetch_valid), 32'(0));

    start_load();
    beat(8'h01, 1'b0);
    beat(8'h02, 1'b0);
    async_clear();
    fetch(0);
    check("post_clear_err", 32'(fetch_err), 32'(1));

    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 599) == 0) async_clear();
      load_start = ($urandom_range(0, 39) == 0);
      load_valid = ($urandom_range(0, 3) != 0);
      load_data  = IW'($urandom_range(0, 255));
      load_last  = ($urandom_range(0, 9) == 0);
      fetch_req  = ($urandom_range(0, 1) == 1);
      fetch_addr = AW'($urandom_range(0, DEPTH - 1));
      step();
    end

    idle_inputs();
    step();
    done = 1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_store.md
# instr_store

Parametrised, loadable instruction store; successor to the fixed 32×8 hard-wired instruction table. A program is streamed in over a valid/ready load port, and the execute stage fetches words with one-cycle registered latency. Out-of-range or not-ready fetches are flagged rather than returning garbage. Sits between the program loader (UART/switch front end) and the instruction decoder.

## Interface

- `IW`, 8, instruction width in bits
- `DEPTH`, 32, number of instruction words (≥2)
- `AW`, $clog2(DEPTH), fetch/write address width (derived, not overridden)

Ports:
- `clk`  in  1  single clock, rising edge
- `clear`  in  1  reset, asynchronous, active-high
- `load_start`  in  1  pulse: begin a new program load
- `load_valid`  in  1  load beat valid
- `load_data`  in  IW  instruction word
- `load_last`  in  1  marks final word of program
- `load_ready`  out  1  store accepts a beat this cycle
- `fetch_req`  in  1  fetch request
- `fetch_addr`  in  AW  fetch address
- `fetch_valid`  out  1  fetch response valid
- `fetch_data`  out  IW  fetched word (0 on error)
- `fetch_err`  out  1  response is an error
- `prog_len`  out  AW+1  words in current program
- `truncated`  out  1  last load hit DEPTH without `load_last`
- `busy`  out  1  state is LOADING

## Operation

- States: EMPTY, LOADING, READY. `clear` → EMPTY, `prog_len`=0, `truncated`=0, `fetch_valid`=0, `fetch_err`=0, `fetch_data`=0, write pointer 0. Array contents are not reset.
- `load_start` from any state → LOADING, write pointer 0, `prog_len`=0, `truncated`=0.
- `load_ready` = LOADING && wr_ptr<DEPTH && !`load_start` (combinational).
- Beat accepted when `load_valid && load_ready`: writes mem[wr_ptr], wr_ptr+1.
  - With `load_last`: → READY, `prog_len`=wr_ptr+1.
  - Without `load_last`, on write to DEPTH-1: → READY, `prog_len`=DEPTH, `truncated`=1.
- `load_start` coincident with a valid beat: restart wins; the beat is not accepted.
- Fetch, when `fetch_req` is sampled:
  - In READY with `fetch_addr`<`prog_len`: next cycle `fetch_valid`=1, `fetch_data`=mem[addr], `fetch_err`=0.
  - Otherwise (EMPTY, LOADING, or addr ≥ `prog_len`): next cycle `fetch_valid`=1, `fetch_err`=1, `fetch_data`=0.
- No `fetch_req` → next cycle `fetch_valid`=0, `fetch_err`=0; `fetch_data` holds its last value.
- `fetch_req` in READY in the same cycle as `load_start`: served from old contents with the old `prog_len`.

## Timing

- Fetch latency is exactly 1 cycle; one request per cycle is accepted with no backpressure.
- Load throughput is 1 word/cycle; `load_ready` falls in the cycle after the final accepted beat (state leaves LOADING).
- `prog_len`, `truncated` and `busy` are registered and update on the edge that accepts the terminating beat.
- Read-during-write cannot occur, because fetches are only served in READY.
- `clear` mid-load aborts immediately (async); all outputs take reset values without waiting for a clock edge.

## Structure

- Package `instr_store_pkg`: state enum (EMPTY/LOADING/READY) and default `IW`/`DEPTH` constants shared with the decoder.
- Sub-module `instr_mem_array`: DEPTH×IW single-write-port, registered-read RAM (no reset). The top level holds the FSM, write pointer, length/flag registers and the error-response mux.

## Test plan

- Reset, then `fetch_req` addr 0 → next cycle `fetch_valid`=1, `fetch_err`=1, `fetch_data`=0; `prog_len`=0.
- Load 0x44,0x49,0x18,0x89,0xC3 (last on 5th) → `prog_len`=5, `truncated`=0; fetch addr 3 → 0x89, err 0; fetch addr 5 → err 1.
- Load 32 words with no `load_last` → `prog_len`=32, `truncated`=1, `load_ready`=0; a 33rd `load_valid` is not accepted.
- `load_start` asserted with `load_valid` on the 3rd beat → that beat is dropped, wr_ptr=0; the next beat lands at addr 0.
- Back-to-back fetches 0,1,2 in READY → responses on consecutive cycles, in order, each 1 cycle late.
- `clear` asserted mid-load (after 2 beats) → asynchronous EMPTY, `busy`=0, `prog_len`=0; a subsequent fetch errors.
